// File: rtl/keypad_pkg.sv
// Shared types and helpers for the debounced keypad encoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_e;

  localparam int MODE_PRIORITY = 0;
  localparam int MODE_STRICT   = 1;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/keypad_encoder_onehot_encoder.sv
// Combinational vector-to-index encoder; STRICT mode flags multi-hot inputs.
module onehot_encoder
  import keypad_pkg::*;
#(
  parameter int N_KEYS = 10,
  parameter int CODE_W = 4,
  parameter int MODE   = MODE_PRIORITY
) (
  input  logic [N_KEYS-1:0] vec,
  output logic [CODE_W-1:0] code,
  output logic              err
);

  int n_set;

  always_comb begin
    code  = '0;
    err   = 1'b0;
    n_set = 0;
    // Ascending scan: the last set bit seen is the highest index.
    for (int i = 0; i < N_KEYS; i++) begin
      if (vec[i]) begin
        code  = CODE_W'(i);
        n_set = n_set + 1;
      end
    end
    if (MODE == MODE_STRICT && n_set > 1) begin
      code = '1;
      err  = 1'b1;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Synchronises, debounces and encodes a raw key vector into a code plus press/release strobes.
//   state | meaning
//   IDLE  | no key candidate, waiting for a non-zero vector
//   DEB   | candidate captured, counting stable cycles toward a press
//   HELD  | press accepted, key_valid high
//   REL   | vector left the candidate, counting stable cycles toward a release
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MODE            = MODE_PRIORITY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_press,
  output logic              key_release,
  output logic              key_err
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (N_KEYS < 2 || DEBOUNCE_CYCLES < 1 || CODE_W < clog2(N_KEYS + 1) ||
      (MODE != MODE_PRIORITY && MODE != MODE_STRICT)) begin : g_bad_params
    $error("keypad_encoder: illegal parameter combination");
  end

  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              err_q, err_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              valid_q, valid_d;

  logic [CODE_W-1:0] enc_code;
  logic              enc_err;

  onehot_encoder #(
    .N_KEYS (N_KEYS),
    .CODE_W (CODE_W),
    .MODE   (MODE)
  ) u_enc (
    .vec  (cand_q),
    .code (enc_code),
    .err  (enc_err)
  );

  always_comb begin
    sync1_d   = keys;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    err_d     = err_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync2_q != '0) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = DEB;
        end
      end
      DEB: begin
        if (sync2_q == '0) begin
          state_d = IDLE;
        end else if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          code_d  = enc_code;
          err_d   = enc_err;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        // Any departure from the candidate, including a different non-zero vector, starts a release.
        if (sync2_q != cand_q) begin
          cnt_d   = '0;
          state_d = REL;
        end
      end
      REL: begin
        if (sync2_q == cand_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == HELD) || (state_d == REL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      err_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      err_q     <= err_d;
      press_q   <= press_d;
      release_q <= release_d;
      valid_q   <= valid_d;
    end
  end

  assign key_code    = code_q;
  assign key_err     = err_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_valid   = valid_q;

endmodule
